// File: rtl/int_ascii_encoder.sv
`default_nettype none
// ============================================================================
// Module      : int_ascii_encoder
// Description : Streams a signed 32-bit integer as ASCII decimal, plus an
//               optional separator, through a tx_start/tx_done byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ascii_encoder #(
    parameter int CLK_GUARD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [1:0]  sep,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        done
);

    localparam int GW = (CLK_GUARD > 0) ? $clog2(CLK_GUARD + 1) : 1;

    localparam logic [1:0] c_SEP_SPACE = 2'b01;
    localparam logic [1:0] c_SEP_CRLF  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SIGN   = 4'd1,
        S_SIGN_W = 4'd2,
        S_DIGIT  = 4'd3,
        S_EMIT   = 4'd4,
        S_EMIT_W = 4'd5,
        S_SEP1   = 4'd6,
        S_SEP1_W = 4'd7,
        S_SEP2   = 4'd8,
        S_SEP2_W = 4'd9,
        S_FIN    = 4'd10
    } state_t;

    state_t          r_state;
    logic [31:0]     r_mag;
    logic [3:0]      r_k;
    logic [3:0]      r_digit;
    logic            r_lead;
    logic [1:0]      r_sep;
    logic [GW-1:0]   r_gcnt;
    logic            r_gact;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_busy;
    logic            r_done;

    logic [31:0]     w_pow;
    logic            w_wait;
    logic            w_adv;

    function automatic logic [31:0] f_pow10(input logic [3:0] k);
        case (k)
            4'd0:    f_pow10 = 32'd1;
            4'd1:    f_pow10 = 32'd10;
            4'd2:    f_pow10 = 32'd100;
            4'd3:    f_pow10 = 32'd1000;
            4'd4:    f_pow10 = 32'd10000;
            4'd5:    f_pow10 = 32'd100000;
            4'd6:    f_pow10 = 32'd1000000;
            4'd7:    f_pow10 = 32'd10000000;
            4'd8:    f_pow10 = 32'd100000000;
            4'd9:    f_pow10 = 32'd1000000000;
            default: f_pow10 = 32'd1;
        endcase
    endfunction

    assign w_pow  = f_pow10(r_k);
    assign w_wait = (r_state == S_SIGN_W) || (r_state == S_EMIT_W) ||
                    (r_state == S_SEP1_W) || (r_state == S_SEP2_W);

    // Advance strobe for the *_W states: tx_done directly, or the last guard cycle.
    assign w_adv  = (CLK_GUARD == 0) ? tx_done : (r_gact && (r_gcnt == GW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_mag      <= 32'd0;
            r_k        <= 4'd0;
            r_digit    <= 4'd0;
            r_lead     <= 1'b0;
            r_sep      <= 2'b00;
            r_gcnt     <= '0;
            r_gact     <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (CLK_GUARD != 0) begin
                if (r_gact) begin
                    if (r_gcnt == GW'(1)) begin
                        r_gact <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end
                end else if (w_wait && tx_done) begin
                    r_gact <= 1'b1;
                    r_gcnt <= GW'(CLK_GUARD);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sep   <= sep;
                        r_mag   <= value[31] ? (~value + 32'd1) : value;
                        r_k     <= 4'd9;
                        r_digit <= 4'd0;
                        r_lead  <= 1'b0;
                        r_busy  <= 1'b1;
                        if (value[31]) begin
                            r_tx_data  <= 8'h2D;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SIGN;
                        end else begin
                            r_state    <= S_DIGIT;
                        end
                    end
                end

                S_SIGN: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_SIGN_W;
                end

                S_SIGN_W: begin
                    if (w_adv) begin
                        r_state <= S_DIGIT;
                    end
                end

                // Repeated subtraction of 10^k; leading zeros are skipped until lead is set.
                S_DIGIT: begin
                    if (r_mag >= w_pow) begin
                        r_mag   <= r_mag - w_pow;
                        r_digit <= r_digit + 4'd1;
                    end else if ((r_digit != 4'd0) || r_lead || (r_k == 4'd0)) begin
                        r_lead     <= 1'b1;
                        r_tx_data  <= 8'h30 + {4'h0, r_digit};
                        r_tx_start <= 1'b1;
                        r_state    <= S_EMIT;
                    end else begin
                        r_k <= r_k - 4'd1;
                    end
                end

                S_EMIT: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_EMIT_W;
                end

                S_EMIT_W: begin
                    if (w_adv) begin
                        if (r_k != 4'd0) begin
                            r_k     <= r_k - 4'd1;
                            r_digit <= 4'd0;
                            r_state <= S_DIGIT;
                        end else if (r_sep == c_SEP_SPACE) begin
                            r_tx_data  <= 8'h20;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEP1;
                        end else if (r_sep == c_SEP_CRLF) begin
                            r_tx_data  <= 8'h0D;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEP1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end

                S_SEP1: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_SEP1_W;
                end

                S_SEP1_W: begin
                    if (w_adv) begin
                        if (r_sep == c_SEP_CRLF) begin
                            r_tx_data  <= 8'h0A;
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEP2;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end

                S_SEP2: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_SEP2_W;
                end

                S_SEP2_W: begin
                    if (w_adv) begin
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_int_ascii_encoder.sv
`default_nettype none
// Directed bench for int_ascii_encoder: a byte-sink model answers each
// tx_start with tx_done 20 cycles later and records every byte sent.
module tb_int_ascii_encoder;

    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic [1:0]  sep = 2'b00;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        done;
    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int epoch = 0;
    int last_txdone = 0;
    int first_start = -1;
    int gap_viol = 0;
    byte unsigned bytes[$];

    assign tx_done = resp_done | spur_done;

    int_ascii_encoder #(.CLK_GUARD(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .sep      (sep),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Byte sink: tx_done 20 cycles after tx_start; pending replies die on reset.
    initial begin
        int cnt;
        int e;
        cnt = 0;
        e = 0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && e == epoch) begin
                    resp_done = 1'b1;
                    last_txdone = cyc;
                end
            end
            if (tx_start) begin
                if (bytes.size() > 0 && (cyc - last_txdone) < (1 + G)) gap_viol++;
                if (bytes.size() == 0) first_start = cyc;
                bytes.push_back(tx_data);
                cnt = 20;
                e = epoch;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] v, input logic [1:0] s, input string exp,
                       input int lat, input bit interfere, input bit spur);
        byte unsigned expq[$];
        int  acc;
        int  dcyc;
        int  extra;
        int  n;
        bit  got_done;
        bit  injected;
        bytes.delete();
        first_start = -1;
        gap_viol = 0;
        dcyc = 0;
        @(negedge clk);
        value = v;
        sep   = s;
        start = 1'b1;
        acc   = cyc;
        @(negedge clk);
        start = 1'b0;
        check({exp, " busy_rise"}, {63'd0, busy}, 64'd1);
        got_done = 1'b0;
        injected = 1'b0;
        for (int i = 0; i < 20000 && !got_done; i++) begin
            @(negedge clk);
            start = 1'b0;
            spur_done = 1'b0;
            if (done) begin
                got_done = 1'b1;
                dcyc = cyc;
            end else begin
                if (spur && cyc == acc + 3) spur_done = 1'b1;
                if (interfere && !injected && bytes.size() >= 2) begin
                    start = 1'b1;
                    value = 32'd9;
                    sep   = 2'b01;
                    injected = 1'b1;
                end
            end
        end
        check({exp, " done_seen"}, {63'd0, got_done}, 64'd1);
        @(negedge clk);
        check({exp, " busy_fall"}, {63'd0, busy}, 64'd0);
        check({exp, " done_latency"}, 64'(dcyc - last_txdone), 64'(1 + G));
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({exp, " extra_done"}, 64'(extra), 64'd0);
        for (int i = 0; i < exp.len(); i++) expq.push_back(exp[i]);
        if (s == 2'b01) expq.push_back(8'h20);
        if (s == 2'b10) begin
            expq.push_back(8'h0D);
            expq.push_back(8'h0A);
        end
        check({exp, " byte_count"}, 64'(bytes.size()), 64'(expq.size()));
        n = (bytes.size() < expq.size()) ? bytes.size() : expq.size();
        for (int i = 0; i < n; i++) check({exp, " byte"}, 64'(bytes[i]), 64'(expq[i]));
        check({exp, " first_latency"}, 64'(first_start - acc), 64'(lat));
        check({exp, " guard_gap"}, 64'(gap_viol), 64'd0);
    endtask

    initial begin
        bit ok;
        int nbytes;
        #3 rst = 1'b0;
        #1;
        check("reset tx_data", 64'(tx_data), 64'h00);
        check("reset tx_start", {63'd0, tx_start}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run(32'd0,          2'b00, "0",           11, 1'b0, 1'b1);
        run(32'd123,        2'b01, "123",         10, 1'b0, 1'b0);
        run(32'h8000_0000,  2'b10, "-2147483648",  1, 1'b0, 1'b0);
        run(32'd1000000007, 2'b00, "1000000007",   3, 1'b0, 1'b0);
        run(32'hFFFF_FFFB,  2'b00, "-5",           1, 1'b0, 1'b0);
        run(32'd123,        2'b11, "123",         10, 1'b1, 1'b0);

        // Reset in the middle of "4567" after its second byte.
        bytes.delete();
        first_start = -1;
        @(negedge clk);
        value = 32'd4567;
        sep   = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (bytes.size() >= 2) ok = 1'b1;
        end
        check("rst second_byte_seen", {63'd0, ok}, 64'd1);
        rst = 1'b0;
        epoch++;
        #1;
        check("rst tx_start", {63'd0, tx_start}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst tx_data", 64'(tx_data), 64'h00);
        nbytes = bytes.size();
        check("rst first_bytes", {48'd0, bytes[0], bytes[1]}, 64'h3435);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (60) @(negedge clk);
        check("rst no_more_bytes", 64'(bytes.size()), 64'(nbytes));
        check("rst stays_idle", {63'd0, busy}, 64'd0);

        run(32'd8, 2'b00, "8", 19, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
